// File: rtl/fsk2_rx.sv
// ---------------------------------------------------------------------------
// fsk2_rx : 2FSK demodulator for the sine-LUT FSK link.
//
// Each bit occupies a fixed window of BIT_CYCLES samples. The sign changes
// (zero crossings) of the incoming sample stream are counted per window. A
// count of at least ZC_THRESH decodes as 1 (2 MHz carrier), otherwise 0
// (1 MHz carrier). DATA_W bits are assembled MSB first into one word.
// Frame alignment comes from an external rx_start strobe.
//
// Ports:
//   sys_clk      in   system clock (50 MHz)
//   sys_rst_n    in   asynchronous active-low reset
//   rx           in   modulated sample, two's complement, one per clock
//   rx_start     in   one-cycle pulse on the first sample of the MSB window
//   data_out     out  last fully received word (held between frames)
//   data_valid   out  one-cycle pulse when data_out updates
//   rx_bit       out  most recently decided bit
//   rx_bit_valid out  one-cycle pulse when rx_bit updates
//   busy         out  high while a frame is being received
// ---------------------------------------------------------------------------
module fsk2_rx #(
  parameter int BIT_CYCLES = 51,
  parameter int SAMPLE_W   = 32,
  parameter int ZC_THRESH  = 4,
  parameter int DATA_W     = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [SAMPLE_W-1:0] rx,
  input  logic                rx_start,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_valid,
  output logic                rx_bit,
  output logic                rx_bit_valid,
  output logic                busy
);

  localparam int SC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    S_IDLE,
    S_RECV
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_prev_sign;
  logic [5:0]        r_zc_cnt;
  logic [SC_W-1:0]   r_sample_cnt;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shift;

  logic              w_crossing;
  logic [6:0]        w_zc_sum;
  logic [5:0]        w_zc_sat;
  logic              w_bit;
  logic              w_window_end;
  logic              w_frame_end;
  logic              w_unused;

  // Only the sign bit matters for crossing detection; the magnitude bits are
  // intentionally ignored.
  assign w_unused = ^rx[SAMPLE_W-2:0];

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    // A zero sample has sign bit 0 and therefore counts as positive.
    w_crossing   = rx[SAMPLE_W-1] ^ r_prev_sign;
    // 7-bit sum so the decision compare cannot overflow at a full count.
    w_zc_sum     = {1'b0, r_zc_cnt} + {6'd0, w_crossing};
    w_zc_sat     = w_zc_sum[6] ? 6'd63 : w_zc_sum[5:0];
    // The window's last sample is included in the decision.
    w_bit        = (w_zc_sum >= 7'(ZC_THRESH));
    w_window_end = (r_state == S_RECV) && (r_sample_cnt == SC_W'(BIT_CYCLES - 1));
    w_frame_end  = w_window_end && (r_bit_cnt == BC_W'(DATA_W - 1));

    case (r_state)
      S_IDLE: if (rx_start)    w_state_nxt = S_RECV;
      S_RECV: if (w_frame_end) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prev_sign  <= 1'b0;
      r_zc_cnt     <= '0;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
    end else begin
      r_prev_sign  <= rx[SAMPLE_W-1];
      data_valid   <= 1'b0;
      rx_bit_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (rx_start) begin
            // The start cycle's sample is the first sample of the MSB window.
            r_zc_cnt     <= {5'd0, w_crossing};
            r_sample_cnt <= SC_W'(1);
            r_bit_cnt    <= '0;
          end
        end

        S_RECV: begin
          if (w_window_end) begin
            r_shift      <= {r_shift[DATA_W-2:0], w_bit};
            rx_bit       <= w_bit;
            rx_bit_valid <= 1'b1;
            r_zc_cnt     <= '0;
            r_sample_cnt <= '0;
            if (w_frame_end) begin
              data_out   <= {r_shift[DATA_W-2:0], w_bit};
              data_valid <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt  <= r_bit_cnt + BC_W'(1);
            end
          end else begin
            r_zc_cnt     <= w_zc_sat;
            r_sample_cnt <= r_sample_cnt + SC_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

  // rx_start is ignored while receiving, so busy is exactly the RECV state.
  assign busy = (r_state == S_RECV);

endmodule

// File: tb/tb_fsk2_rx.sv
// ---------------------------------------------------------------------------
// tb_fsk2_rx : self-checking bench for fsk2_rx.
//
// Every driven sample is reduced to a crossing flag (its sign differs from
// the previous sample's sign; previous sign is 0 right after reset) and kept
// in a queue indexed by clock edge. The reference decodes a frame started at
// edge s by summing those flags over each 51-sample window, saturating at 63
// and comparing with 4. Observed data_valid/rx_bit_valid events are queued by
// a negedge monitor and matched against the reference afterwards.
// ---------------------------------------------------------------------------
module tb_fsk2_rx;

  localparam int BC = 51;
  localparam int DW = 16;
  localparam int FL = BC * DW;  // samples per frame

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] rx;
  logic        rx_start;
  logic        rx_start_sat;
  logic [15:0] data_out;
  logic        data_valid, rx_bit, rx_bit_valid, busy;
  logic [1:0]  sat_data_out;
  logic        sat_data_valid, sat_rx_bit, sat_rx_bit_valid, sat_busy;

  fsk2_rx dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx), .rx_start(rx_start),
    .data_out(data_out), .data_valid(data_valid), .rx_bit(rx_bit),
    .rx_bit_valid(rx_bit_valid), .busy(busy)
  );

  // Longer windows so a full-toggle window (66 crossings) exceeds 63 and
  // would wrap to 2 without saturation.
  fsk2_rx #(.BIT_CYCLES(66), .DATA_W(2)) u_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx), .rx_start(rx_start_sat),
    .data_out(sat_data_out), .data_valid(sat_data_valid), .rx_bit(sat_rx_bit),
    .rx_bit_valid(sat_rx_bit_valid), .busy(sat_busy)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    bit          synth;   // 1: synthetic square wave, 0: FSK LUT carrier
    logic [15:0] word;
    int          lo;      // synthetic crossings in a 0 window
    int          hi;      // synthetic crossings in a 1 window
    int          ign_a;   // extra rx_start offsets inside the frame (-1 none)
    int          ign_b;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[8];
  int          total = 0;
  int          bad   = 0;
  int          edge_cnt = -1;
  int          acc = 0;          // carrier phase, 1/50 of a 1 MHz period
  bit          model_prev = 1'b0;
  int          active_start = -1;
  bit          xq[$];
  int          starts[$];
  int          dv_edge[$];
  logic [15:0] dv_word[$];
  bit          rb_bits[$];
  int          rb_edge[$];
  int          sat_dv_cnt = 0;
  logic [1:0]  sat_word = '0;

  always @(negedge sys_clk) begin
    if (data_valid) begin
      dv_edge.push_back(edge_cnt);
      dv_word.push_back(data_out);
    end
    if (rx_bit_valid) begin
      rb_bits.push_back(rx_bit);
      rb_edge.push_back(edge_cnt);
    end
    if (sat_data_valid) begin
      sat_dv_cnt++;
      sat_word = sat_data_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sign-accurate stand-in for the transmitter LUT: non-negative over the
  // first half period (phase 0 gives an exact zero), negative over the second.
  function automatic logic [31:0] lut(input int a);
    if (a < 25) return 32'(a * 1000);
    return 32'(-((a - 25) * 1000 + 1));
  endfunction

  task automatic drive(input logic [31:0] s, input bit start);
    rx       = s;
    rx_start = start;
    @(posedge sys_clk);
    xq.push_back(sys_rst_n ? (s[31] ^ model_prev) : 1'b0);
    model_prev = sys_rst_n ? s[31] : 1'b0;
    edge_cnt   = xq.size() - 1;
    if (start && sys_rst_n && (active_start < 0 || edge_cnt >= active_start + FL)) begin
      starts.push_back(edge_cnt);
      active_start = edge_cnt;
    end
    #1;
    rx_start = 1'b0;
  endtask

  task automatic sine_sample(input int step, input bit start);
    drive(lut(acc), start);
    acc = (acc + step) % 50;
  endtask

  task automatic idle(input int n);
    repeat (n) sine_sample(1, 1'b0);
  endtask

  task automatic send_frame(input bit synth, input logic [15:0] word, input int lo,
                            input int hi, input int ign_a, input int ign_b);
    for (int k = 0; k < DW; k++) begin
      for (int i = 0; i < BC; i++) begin
        int off;
        bit st;
        bit sg;
        int n;
        off = k * BC + i;
        st  = (off == 0) || (off == ign_a) || (off == ign_b);
        if (!synth) begin
          sine_sample(word[DW-1-k] ? 2 : 1, st);
        end else begin
          n  = word[DW-1-k] ? hi : lo;
          sg = (i < n) ? ~model_prev : model_prev;
          if (sg) drive(32'hFFFF_FF00 | 32'($urandom_range(0, 255)), st);
          else    drive((i % 3 == 0) ? 32'd0 : 32'($urandom_range(1, 1000)), st);
        end
      end
    end
  endtask

  task automatic check_frames();
    while (starts.size() > 0) begin
      int          s;
      int          cnt;
      logic [15:0] w;
      logic [15:0] rbw;
      bit          edges_ok;
      s = starts.pop_front();
      w = '0;
      for (int k = 0; k < DW; k++) begin
        cnt = 0;
        for (int i = 0; i < BC; i++) cnt += int'(xq[s + k * BC + i]);
        if (cnt > 63) cnt = 63;
        w = {w[14:0], (cnt >= 4)};
      end
      if (dv_edge.size() == 0) begin
        check("data_valid_present", 32'd0, 32'd1);
      end else begin
        check("data_valid_edge", 32'(dv_edge.pop_front()), 32'(s + FL - 1));
        check("data_out_word", 32'(dv_word.pop_front()), 32'(w));
      end
      if (rb_bits.size() < DW) begin
        check("rx_bit_count", 32'(rb_bits.size()), 32'(DW));
        rb_bits.delete();
        rb_edge.delete();
      end else begin
        rbw      = '0;
        edges_ok = 1'b1;
        for (int k = 0; k < DW; k++) begin
          rbw = {rbw[14:0], rb_bits.pop_front()};
          if (rb_edge.pop_front() != s + k * BC + BC - 1) edges_ok = 1'b0;
        end
        check("rx_bit_sequence", 32'(rbw), 32'(w));
        check("rx_bit_valid_timing", 32'(edges_ok), 32'd1);
      end
    end
    check("no_extra_data_valid", 32'(dv_edge.size()), 32'd0);
    check("no_extra_rx_bit_valid", 32'(rb_bits.size()), 32'd0);
    dv_edge.delete();
    dv_word.delete();
    rb_bits.delete();
    rb_edge.delete();
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 0, 0,  -1,  -1, 16'h0000};
    vecs[1] = '{1'b0, 16'hA5C3, 0, 0, 100, 815, 16'hA5C3};
    vecs[2] = '{1'b0, 16'hFFFF, 0, 0,  -1,  -1, 16'hFFFF};
    vecs[3] = '{1'b0, 16'h0000, 0, 0,  -1,  -1, 16'h0000};
    vecs[4] = '{1'b1, 16'h5A3C, 3, 4,  -1,  -1, 16'h5A3C};
    vecs[5] = '{1'b1, 16'h0F0F, 0, 51, -1,  -1, 16'h0F0F};
    vecs[6] = '{1'b1, 16'hFFFF, 2, 4,  -1,  -1, 16'hFFFF};
    vecs[7] = '{1'b1, 16'h1234, 3, 3,  -1,  -1, 16'h0000};

    sys_rst_n    = 1'b0;
    rx           = '0;
    rx_start     = 1'b0;
    rx_start_sat = 1'b0;
    repeat (3) drive(32'd0, 1'b0);
    sys_rst_n = 1'b1;
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_rx_bit", 32'(rx_bit), 32'd0);
    check("reset_rx_bit_valid", 32'(rx_bit_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    idle(5);

    // Table: frames back to back; vector 1 also carries ignored starts.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].synth, vecs[v].word, vecs[v].lo, vecs[v].hi,
                 vecs[v].ign_a, vecs[v].ign_b);
      check($sformatf("vec%0d_data_valid", v), 32'(data_valid), 32'd1);
      check($sformatf("vec%0d_data_out", v), 32'(data_out), 32'(vecs[v].exp));
    end
    idle(3);
    check_frames();

    // Reset in the middle of a frame.
    sine_sample(2, 1'b1);
    repeat (399) sine_sample(2, 1'b0);
    check("busy_mid_frame", 32'(busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_out_held", 32'(data_out), 32'(vecs[7].exp));
    check("abort_sample_cnt", 32'(dut.r_sample_cnt), 32'd0);
    check("abort_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);
    check("abort_zc_cnt", 32'(dut.r_zc_cnt), 32'd0);
    check("abort_bits_before_reset", 32'(rb_bits.size()), 32'd7);
    void'(starts.pop_back());
    active_start = -1;
    rb_bits.delete();
    rb_edge.delete();
    repeat (3) sine_sample(1, 1'b0);
    sys_rst_n = 1'b1;
    idle(900);
    check_frames();
    send_frame(1'b0, 16'h3C5A, 0, 0, -1, -1);
    check("after_reset_data_out", 32'(data_out), 32'h3C5A);
    idle(3);
    check_frames();

    // Saturation on the long-window instance: every sample toggles.
    rx_start_sat = 1'b1;
    for (int i = 0; i < 132; i++) begin
      drive(model_prev ? 32'd5 : 32'hFFFF_FFF0, 1'b0);
      rx_start_sat = 1'b0;
    end
    idle(3);
    check("sat_data_valid_count", 32'(sat_dv_cnt), 32'd1);
    check("sat_no_wrap_word", 32'(sat_word), 32'h3);
    check_frames();

    // Randomised frames against the reference.
    for (int f = 0; f < 20; f++) begin
      int          gap;
      int          ign;
      logic [15:0] w;
      gap = $urandom_range(0, 3);
      w   = 16'($urandom);
      ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FL - 1)) : -1;
      idle(gap);
      if ($urandom_range(0, 1) == 1)
        send_frame(1'b0, w, 0, 0, ign, -1);
      else
        send_frame(1'b1, w, $urandom_range(0, 3), $urandom_range(4, 51), ign, -1);
    end
    idle(3);
    check_frames();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
